// File: rtl/motion_driver.sv
// Two-axis step/direction pulse generator with signed position tracking and a pen servo PWM.
// Each axis runs Idle -> Setup -> Pulse -> Wait, and the rise-to-rise spacing is timed from the rise.
module motion_driver #(
    parameter int unsigned PULSE_WIDTH  = 4,
    parameter int unsigned DIR_SETUP    = 2,
    parameter int unsigned MIN_INTERVAL = 8,
    parameter int unsigned SERVO_PERIOD = 1000000,
    parameter int unsigned SERVO_UP_W   = 50000,
    parameter int unsigned SERVO_DOWN_W = 100000
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] xSpeed,
    input  logic [31:0] ySpeed,
    input  logic [31:0] xDirection,
    input  logic [31:0] yDirection,
    input  logic [31:0] servo,
    input  logic        zero_req,
    output logic        x_step,
    output logic        y_step,
    output logic        x_dir,
    output logic        y_dir,
    output logic        servo_pwm,
    output logic [31:0] currentX,
    output logic [31:0] currentY
);

    localparam logic [23:0] PulseLen   = 24'(PULSE_WIDTH);
    localparam logic [23:0] SetupLen   = 24'(DIR_SETUP);
    localparam logic [23:0] MinIval    = 24'(MIN_INTERVAL);
    localparam logic [31:0] PeriodLast = 32'(SERVO_PERIOD - 1);
    localparam logic [31:0] UpWidth    = 32'(SERVO_UP_W);
    localparam logic [31:0] DownWidth  = 32'(SERVO_DOWN_W);

    if (PULSE_WIDTH < 1) begin : gBadPulse
        $error("PULSE_WIDTH must be at least 1");
    end
    if (DIR_SETUP < 1) begin : gBadSetup
        $error("DIR_SETUP must be at least 1");
    end
    if (MIN_INTERVAL < PULSE_WIDTH + 2) begin : gBadInterval
        $error("MIN_INTERVAL must be at least PULSE_WIDTH + 2");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StWait} axisState_e;

    logic [1:0][23:0] speedIn;
    logic [1:0]       dirIn;
    logic [1:0]       stepVec;
    logic [1:0]       dirVec;
    logic [1:0][31:0] posVec;

    assign speedIn = {ySpeed[23:0], xSpeed[23:0]};
    assign dirIn   = {yDirection[0], xDirection[0]};

    // Only the low speed bits and bit 0 of the direction/servo words carry meaning.
    logic unusedInputs;
    assign unusedInputs = ^{xSpeed[31:24], ySpeed[31:24], xDirection[31:1], yDirection[31:1],
                            servo[31:1]};

    function automatic logic [23:0] clampInterval(input logic [23:0] speed);
        return (speed < MinIval) ? MinIval : speed;
    endfunction

    function automatic logic [31:0] stepPos(input logic [31:0] pos, input logic dir);
        return dir ? pos + 32'd1 : pos - 32'd1;
    endfunction

    for (genvar a = 0; a < 2; a++) begin : gAxis
        axisState_e  state;
        logic [23:0] phaseCnt;
        logic [23:0] interval;
        logic        step;
        logic        dir;
        logic [31:0] pos;

        // phaseCnt counts cycles since entering Setup, or since the step rise in Pulse/Wait.
        always_ff @(posedge clock) begin
            if (ctrl_reset) begin
                state    <= StIdle;
                phaseCnt <= '0;
                interval <= '0;
                step     <= 1'b0;
                dir      <= 1'b0;
                pos      <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (speedIn[a] != '0) begin
                            dir      <= dirIn[a];
                            state    <= StSetup;
                            phaseCnt <= 24'd1;
                        end
                    end
                    StSetup: begin
                        if (phaseCnt == SetupLen) begin
                            state    <= StPulse;
                            step     <= 1'b1;
                            interval <= clampInterval(speedIn[a]);
                            pos      <= stepPos(pos, dir);
                            phaseCnt <= 24'd1;
                        end else begin
                            phaseCnt <= phaseCnt + 24'd1;
                        end
                    end
                    StPulse: begin
                        if (phaseCnt == PulseLen) begin
                            state <= StWait;
                            step  <= 1'b0;
                        end
                        phaseCnt <= phaseCnt + 24'd1;
                    end
                    StWait: begin
                        if (phaseCnt == interval) begin
                            if (speedIn[a] == '0) begin
                                state    <= StIdle;
                                phaseCnt <= '0;
                            end else if (dirIn[a] != dir) begin
                                dir      <= dirIn[a];
                                state    <= StSetup;
                                phaseCnt <= 24'd1;
                            end else begin
                                state    <= StPulse;
                                step     <= 1'b1;
                                interval <= clampInterval(speedIn[a]);
                                pos      <= stepPos(pos, dir);
                                phaseCnt <= 24'd1;
                            end
                        end else begin
                            phaseCnt <= phaseCnt + 24'd1;
                        end
                    end
                    default: begin
                        state    <= StIdle;
                        step     <= 1'b0;
                        phaseCnt <= '0;
                    end
                endcase
                // Zeroing wins over a step landing on the same edge.
                if (zero_req) begin
                    pos <= '0;
                end
            end
        end

        assign stepVec[a] = step;
        assign dirVec[a]  = dir;
        assign posVec[a]  = pos;
    end

    logic [31:0] frameCnt;
    logic [31:0] pwmWidth;
    logic [31:0] frameWidth;
    logic        pwmQ;

    // The width for slot 0 is chosen from the servo input seen on that same edge.
    assign frameWidth = (frameCnt == '0) ? (servo[0] ? DownWidth : UpWidth) : pwmWidth;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            frameCnt <= '0;
            pwmWidth <= UpWidth;
            pwmQ     <= 1'b0;
        end else begin
            if (frameCnt == '0) begin
                pwmWidth <= frameWidth;
            end
            pwmQ     <= (frameCnt < frameWidth);
            frameCnt <= (frameCnt == PeriodLast) ? '0 : frameCnt + 32'd1;
        end
    end

    assign x_step    = stepVec[0];
    assign y_step    = stepVec[1];
    assign x_dir     = dirVec[0];
    assign y_dir     = dirVec[1];
    assign currentX  = posVec[0];
    assign currentY  = posVec[1];
    assign servo_pwm = pwmQ;

endmodule

// File: tb/tb_motion_driver.sv
// Scoreboard bench for motion_driver: an event-timed model predicts step rises and servo frames,
// and a negedge monitor compares every observed rise/fall against the queued predictions.
module tb_motion_driver;

    localparam int PW   = 4;
    localparam int DS   = 2;
    localparam int MINI = 8;
    localparam int SP   = 100;
    localparam int UPW  = 10;
    localparam int DNW  = 30;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic [31:0] xSpeed, ySpeed, xDirection, yDirection, servo;
    logic        zero_req;
    logic        x_step, y_step, x_dir, y_dir, servo_pwm;
    logic [31:0] currentX, currentY;

    always #5 clock = ~clock;

    motion_driver #(
        .PULSE_WIDTH (PW),
        .DIR_SETUP   (DS),
        .MIN_INTERVAL(MINI),
        .SERVO_PERIOD(SP),
        .SERVO_UP_W  (UPW),
        .SERVO_DOWN_W(DNW)
    ) dut (
        .clock     (clock),
        .ctrl_reset(ctrl_reset),
        .xSpeed    (xSpeed),
        .ySpeed    (ySpeed),
        .xDirection(xDirection),
        .yDirection(yDirection),
        .servo     (servo),
        .zero_req  (zero_req),
        .x_step    (x_step),
        .y_step    (y_step),
        .x_dir     (x_dir),
        .y_dir     (y_dir),
        .servo_pwm (servo_pwm),
        .currentX  (currentX),
        .currentY  (currentY)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] pos;
        logic        dir;
    } stepExp_t;

    typedef struct {
        int cyc;
        int width;
    } servoExp_t;

    stepExp_t  stepQ [2][$];
    servoExp_t servoQ[$];

    // Reference model: mode 0 = stopped, 1 = waiting for a scheduled first rise, 2 = stepping.
    int          cyc = 0;
    int          mMode[2] = '{0, 0};
    int          mRiseAt[2], mLastRise[2], mIval[2];
    logic        mDir[2];
    logic [31:0] mPos[2];
    int          mFrame = 0;

    always @(posedge clock) begin
        logic [23:0] spd;
        logic        din;
        bit          rise;
        cyc = cyc + 1;
        #1;
        for (int a = 0; a < 2; a++) begin
            spd  = (a == 0) ? xSpeed[23:0] : ySpeed[23:0];
            din  = (a == 0) ? xDirection[0] : yDirection[0];
            rise = 0;
            if (ctrl_reset) begin
                mMode[a] = 0;
                mDir[a]  = 1'b0;
                mPos[a]  = '0;
            end else begin
                if (mMode[a] == 0) begin
                    if (spd != 0) begin
                        mDir[a]    = din;
                        mMode[a]   = 1;
                        mRiseAt[a] = cyc + DS;
                    end
                end else if (mMode[a] == 1) begin
                    if (cyc == mRiseAt[a]) rise = 1;
                end else if (cyc == mLastRise[a] + mIval[a]) begin
                    if (spd == 0) begin
                        mMode[a] = 0;
                    end else if (din != mDir[a]) begin
                        mDir[a]    = din;
                        mMode[a]   = 1;
                        mRiseAt[a] = cyc + DS;
                    end else begin
                        rise = 1;
                    end
                end
                if (rise) begin
                    mMode[a]     = 2;
                    mLastRise[a] = cyc;
                    mIval[a]     = (int'(spd) < MINI) ? MINI : int'(spd);
                    mPos[a]      = mDir[a] ? mPos[a] + 32'd1 : mPos[a] - 32'd1;
                end
                if (zero_req) mPos[a] = '0;
                if (rise) stepQ[a].push_back('{cyc, mPos[a], mDir[a]});
            end
        end
        if (ctrl_reset) begin
            mFrame = 0;
        end else begin
            if (mFrame == 0) servoQ.push_back('{cyc, servo[0] ? DNW : UPW});
            mFrame = (mFrame + 1) % SP;
        end
    end

    logic prevStep[2] = '{1'b0, 1'b0};
    int   riseCyc[2];
    bit   stepAbort[2];
    logic prevPwm = 1'b0;
    int   pwmRise, pwmWidth;
    bit   pwmAbort;

    always @(negedge clock) begin
        logic        s, d;
        logic [31:0] p;
        string       ax;
        stepExp_t    e;
        servoExp_t   se;
        for (int a = 0; a < 2; a++) begin
            s  = (a == 0) ? x_step : y_step;
            d  = (a == 0) ? x_dir : y_dir;
            p  = (a == 0) ? currentX : currentY;
            ax = (a == 0) ? "x" : "y";
            if (s === 1'b1 && prevStep[a] !== 1'b1) begin
                riseCyc[a]   = cyc;
                stepAbort[a] = 0;
                if (stepQ[a].size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL %s step rise: got rise at cycle %0d expected no rise", ax, cyc);
                end else begin
                    e = stepQ[a].pop_front();
                    check($sformatf("%s rise cycle", ax), 32'(cyc), 32'(e.cyc));
                    check($sformatf("%s position at rise", ax), p, e.pos);
                    check($sformatf("%s dir at rise", ax), 32'(d), 32'(e.dir));
                end
            end else if (stepQ[a].size() > 0 && stepQ[a][0].cyc <= cyc) begin
                e = stepQ[a].pop_front();
                nChecks++;
                nFails++;
                $display("FAIL %s step missing: got no rise by cycle %0d expected rise at %0d",
                         ax, cyc, e.cyc);
            end
            if (ctrl_reset) stepAbort[a] = 1;
            if (s === 1'b0 && prevStep[a] === 1'b1 && !stepAbort[a])
                check($sformatf("%s pulse width", ax), 32'(cyc - riseCyc[a]), 32'(PW));
            prevStep[a] = s;
        end

        if (servo_pwm === 1'b1 && prevPwm !== 1'b1) begin
            pwmRise  = cyc;
            pwmAbort = 0;
            if (servoQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL servo frame start: got rise at cycle %0d expected no rise", cyc);
                pwmWidth = 0;
            end else begin
                se       = servoQ.pop_front();
                pwmWidth = se.width;
                check("servo frame start cycle", 32'(cyc), 32'(se.cyc));
            end
        end else if (servoQ.size() > 0 && servoQ[0].cyc <= cyc) begin
            se = servoQ.pop_front();
            nChecks++;
            nFails++;
            $display("FAIL servo frame missing: got no rise by cycle %0d expected rise at %0d",
                     cyc, se.cyc);
        end
        if (ctrl_reset) pwmAbort = 1;
        if (servo_pwm === 1'b0 && prevPwm === 1'b1 && !pwmAbort)
            check("servo high time", 32'(cyc - pwmRise), 32'(pwmWidth));
        prevPwm = servo_pwm;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic waitLevel(input int a, input logic lvl, input int maxCyc);
        int n = 0;
        while (((a == 0) ? x_step : y_step) !== lvl && n < maxCyc) begin
            tick(1);
            n++;
        end
        if (((a == 0) ? x_step : y_step) !== lvl) begin
            nChecks++;
            nFails++;
            $display("FAIL wait axis %0d step=%0b: got timeout after %0d cycles expected level",
                     a, lvl, maxCyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " x_step"}, 32'(x_step), 32'd0);
        check({tag, " y_step"}, 32'(y_step), 32'd0);
        check({tag, " x_dir"}, 32'(x_dir), 32'd0);
        check({tag, " y_dir"}, 32'(y_dir), 32'd0);
        check({tag, " servo_pwm"}, 32'(servo_pwm), 32'd0);
        check({tag, " currentX"}, currentX, 32'd0);
        check({tag, " currentY"}, currentY, 32'd0);
    endtask

    function automatic logic [31:0] randSpeed();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r[23:0] = '0;
        else r[23:0] = 24'($urandom_range(1, 30));
        return r;
    endfunction

    initial begin
        ctrl_reset = 1'b1;
        zero_req   = 1'b0;
        xSpeed     = '0;
        ySpeed     = '0;
        xDirection = '0;
        yDirection = '0;
        servo      = '0;
        tick(3);
        checkAllZero("reset");
        ctrl_reset = 1'b0;

        // Single axis at 20 clocks per step, positive direction.
        xSpeed     = 32'd20;
        xDirection = 32'd1;
        tick(70);
        servo = 32'd1;

        // Reverse mid-interval.
        waitLevel(0, 1'b1, 40);
        tick(8);
        xDirection = 32'd0;
        tick(60);

        // Clamped y axis, then stop during a pulse.
        ySpeed     = 32'd3;
        yDirection = 32'd1;
        tick(40);
        waitLevel(1, 1'b1, 20);
        ySpeed = 32'd0;
        tick(30);

        // zero_req on the same edge as an x rise.
        waitLevel(0, 1'b0, 20);
        waitLevel(0, 1'b1, 30);
        tick(19);
        zero_req = 1'b1;
        tick(1);
        check("zero-on-rise x_step", 32'(x_step), 32'd1);
        check("zero-on-rise currentX", currentX, 32'd0);
        zero_req = 1'b0;

        // Wrap below zero on y.
        zero_req = 1'b1;
        tick(1);
        zero_req   = 1'b0;
        yDirection = 32'd0;
        ySpeed     = 32'd10;
        waitLevel(1, 1'b1, 20);
        ySpeed = 32'd0;
        check("wrap currentY", currentY, 32'hFFFF_FFFF);
        tick(20);

        // Reset while the x step is high, with zero_req also asserted.
        waitLevel(0, 1'b1, 40);
        ctrl_reset = 1'b1;
        zero_req   = 1'b1;
        tick(1);
        checkAllZero("mid-pulse reset");
        zero_req   = 1'b0;
        xDirection = 32'd1;
        ctrl_reset = 1'b0;
        tick(60);

        for (int s = 0; s < 60; s++) begin
            int n;
            xSpeed     = randSpeed();
            ySpeed     = randSpeed();
            xDirection = $urandom;
            yDirection = $urandom;
            servo      = $urandom;
            n          = $urandom_range(5, 60);
            for (int i = 0; i < n; i++) begin
                zero_req   = ($urandom_range(0, 40) == 0);
                ctrl_reset = ($urandom_range(0, 150) == 0);
                tick(1);
            end
            zero_req   = 1'b0;
            ctrl_reset = 1'b0;
        end

        xSpeed = '0;
        ySpeed = '0;
        tick(80);
        check("x pending rises", 32'(stepQ[0].size()), 32'd0);
        check("y pending rises", 32'(stepQ[1].size()), 32'd0);
        check("final currentX", currentX, mPos[0]);
        check("final currentY", currentY, mPos[1]);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/motion_driver.md
MOTION_DRIVER -- requirements
Module: motion_driver

Interface
REQ-001 SHALL have parameter PULSE_WIDTH, default 4; step-pulse high time in clocks.
REQ-002 SHALL have parameter DIR_SETUP, default 2; clocks the dir output must be stable before a step rises.
REQ-003 SHALL have parameter MIN_INTERVAL, default 8; minimum clocks between step rises, and MIN_INTERVAL >= PULSE_WIDTH+2.
REQ-004 SHALL have parameter SERVO_PERIOD, default 1000000; PWM frame length in clocks.
REQ-005 SHALL have parameters SERVO_UP_W, default 50000, and SERVO_DOWN_W, default 100000; PWM high times in clocks.
REQ-006 SHALL have port clock, input, 1 bit; the sole clock, rising edge.
REQ-007 SHALL have port ctrl_reset, input, 1 bit; synchronous, active-high reset.
REQ-008 SHALL have ports xSpeed and ySpeed, input, 32 bits each; step interval in clocks, taken from bits [23:0], where 0 means stop.
REQ-009 SHALL have ports xDirection and yDirection, input, 32 bits each; bit0 set to 1 means positive motion.
REQ-010 SHALL have port servo, input, 32 bits; bit0 set to 1 means pen down.
REQ-011 SHALL have port zero_req, input, 1 bit; a level that clears both positions.
REQ-012 SHALL have ports x_step and y_step, output, 1 bit each; the step pulses.
REQ-013 SHALL have ports x_dir and y_dir, output, 1 bit each; the driver direction pins.
REQ-014 SHALL have port servo_pwm, output, 1 bit; the servo control waveform.
REQ-015 SHALL have ports currentX and currentY, output, 32 bits each; signed step positions.

Function
REQ-016 SHALL implement one identical axis FSM per axis with states IDLE, SETUP, PULSE, WAIT; the x and y axes are fully independent.
REQ-017 SHALL, in IDLE with speed[23:0]!=0: at that edge load dir output from Direction[0], enter SETUP, with step held 0.
REQ-018 SHALL hold SETUP for exactly DIR_SETUP cycles, then enter PULSE.
REQ-019 SHALL, on entering PULSE: drive step=1 on the same edge, latch interval = max(speed[23:0], MIN_INTERVAL), and add or subtract 1 to position per the dir output.
REQ-020 SHALL hold step high for exactly PULSE_WIDTH cycles, then enter WAIT with step=0.
REQ-021 SHALL leave WAIT exactly interval cycles after the step rise, sampling inputs at that edge:
  - speed==0: go to IDLE.
  - Direction[0]!=dir: update dir at that edge and go to SETUP.
  - otherwise: go to PULSE, so the next rise lands exactly interval cycles after the previous one.
REQ-022 SHALL ignore speed and direction changes mid-interval; the in-flight pulse always completes.
REQ-023 SHALL wrap position mod 2^32 in two's complement (0x7FFFFFFF +1 -> 0x80000000; 0 -1 -> 0xFFFFFFFF).
REQ-024 SHALL set both positions to 0 at any edge with zero_req=1; zero_req overrides a same-cycle step update; the FSMs are unaffected.
REQ-025 SHALL run the servo frame counter 0..SERVO_PERIOD-1, wrapping to 0.
REQ-026 SHALL latch servo width at counter==0 (SERVO_DOWN_W if servo[0], else SERVO_UP_W), and drive servo_pwm=1 while counter < latched width.
REQ-027 SHALL make every output registered, with no combinational input-to-output path.

Reset
REQ-028 SHALL, with ctrl_reset=1 at an edge, set: both FSMs to IDLE; x_step, y_step, x_dir, y_dir, servo_pwm to 0; currentX, currentY to 0; all counters to 0; latched width to SERVO_UP_W.
REQ-029 SHALL abort immediately on reset mid-pulse or mid-interval (step low the next cycle), and hold reset over zero_req and all other inputs.
REQ-030 SHALL begin normal operation at the first edge after ctrl_reset deasserts, with that edge treated as servo counter==0.

Verification
REQ-031 SHALL cover single-axis stepping:
  - Stimulus: defaults; xSpeed=20, xDirection=1 held.
  - Response: x_dir=1, step rises 2 cycles later, high 4 cycles, rises every 20 cycles; currentX=1,2,3 at the rises.
REQ-032 SHALL cover reversal:
  - Stimulus: xDirection to 0 mid-interval.
  - Response: the current interval completes; x_dir drops at the 20-cycle edge; the next rise is 22 cycles after the previous one; currentX decrements.
REQ-033 SHALL cover the speed clamp:
  - Stimulus: ySpeed=3.
  - Response: rises every 8 cycles.
  - Stimulus: ySpeed set to 0 mid-pulse.
  - Response: the pulse completes; IDLE after the interval; no further rises.
REQ-034 SHALL cover zero and wrap:
  - Stimulus: zero_req on the same edge as a step rise.
  - Response: currentX=0.
  - Stimulus: from position 0, direction negative, one step.
  - Response: currentY=0xFFFFFFFF.
REQ-035 SHALL cover the servo with overrides:
  - Stimulus: SERVO_PERIOD=100, UP_W=10, DOWN_W=30; servo toggled to 1 mid-frame.
  - Response: current frame high 10 cycles, next frame high 30 cycles, period 100.
REQ-036 SHALL cover reset mid-operation:
  - Stimulus: ctrl_reset asserted during step high.
  - Response: next cycle all outputs 0, positions 0; restart matches REQ-031 timing.
